bpu_btb: RTL and testbench
==========================

# bpu_btb

Parametrised branch predictor for the fetch stage: a fully associative branch target buffer (BTB) with per-entry saturating counters, plus a circular return address stack (RAS). The IFU looks up a PC and gets a same-cycle prediction. The EXU sends resolved control-flow outcomes back through a single update port. Compared with the current predictor, this block adds:
- entry valid bits
- hit-in-place update, so the BTB never holds duplicate tags
- allocation only for taken outcomes, preferring an invalid entry
- configurable counter width
- a wrap-on-overflow RAS driven only by resolved outcomes
- a global invalidate

## Interface
- ADDR_BITS, 30: tag width (PC[31:2]).
- DATA_BITS, 32: target width.
- ENTRIES, 8: BTB entries, a power of two, at least 2.
- CNT_BITS, 2: saturating counter width, at least 1.
- RAS_DEPTH, 4: RAS entries, a power of two, at least 2.
- IDX_W, $clog2(ENTRIES): index width (derived).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  lookup request.
- req_pc  in  ADDR_BITS  lookup tag.
- resp_hit  out  1  a valid entry matches req_pc.
- resp_taken  out  1  resp_hit and predicted taken.
- resp_idx  out  IDX_W  index of the matching entry; 0 on a miss.
- resp_target  out  DATA_BITS  predicted target; 0 when not resp_hit.
- upd_valid  in  1  resolved control-flow instruction.
- upd_pc  in  ADDR_BITS  tag of the instruction.
- upd_kind  in  2  00 branch, 01 jump, 10 call, 11 ret.
- upd_taken  in  1  actual direction; jump, call and ret are always taken.
- upd_target  in  DATA_BITS  actual target.
- upd_ras_push  in  1  push upd_ras_pc.
- upd_ras_pop  in  1  pop the RAS.
- upd_ras_pc  in  DATA_BITS  return address to push.
- inv_valid  in  1  invalidate all BTB entries (fence.i).

## Operation
- **Entry contents:** valid, tag, target, counter, kind.
- **Lookup:** combinational. A hit requires req_valid and a valid entry with a matching tag. If several entries match, the lowest index wins; this only happens after an X-corrupted write.
- **Direction:** resp_taken = hit and counter MSB.
- **Target:** if the hit entry has kind ret and the RAS is not empty, resp_target = RAS top. Otherwise it is the entry's target.
- **Update port:** performs its own tag match on upd_pc, independent of the lookup port.
- **Update, hit:**
  - The counter moves +1 if taken, −1 if not, saturating at all-ones and at 0.
  - Jump, call and ret force the counter to all-ones.
  - If taken, the target and kind are rewritten.
- **Update, miss and taken:** allocate a new entry.
  - Slot choice: the lowest-index invalid entry; if none, the round-robin pointer rr, which then increments modulo ENTRIES.
  - The counter initialises to weak-taken (MSB=1, other bits 0) for a branch, or all-ones for any other kind.
- **Update, miss and not taken:** no BTB change.
- **RAS:** a circular buffer with top pointer sp and count cnt (0..RAS_DEPTH).
  - Push: sp+1 mod depth, write the entry, cnt saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten.
  - Pop: if cnt>0, sp−1 and cnt−1. If cnt==0, no change.
  - Push and pop together: overwrite the top entry only; sp and cnt are unchanged, or behave as a plain push if cnt==0.
  - The RAS responds to upd_ras_* regardless of upd_valid.
- **Invalidate:** inv_valid clears every valid bit and resets rr to 0. It has priority over a same-cycle BTB update, which is dropped. The RAS is untouched.

## Timing
- **Reset:** all valid bits, tags, targets, counters, rr, sp and cnt are 0. All outputs are 0 during and after reset until the first hit.
- **Lookup latency:** 0 cycles (combinational from registers); there is no ready signal and every request is accepted.
- **Update latency:** updates commit at the clk edge, and a lookup in the same cycle sees pre-update state. The new state is visible to a lookup on the cycle after upd_valid.
- **Reset mid-operation:** asynchronous clear of all state. Updates in flight are lost.
- **Allocation ordering:** an allocation that fills the last invalid entry leaves rr unchanged. rr advances only on allocations that evict a valid entry.

## Test plan
- Reset, then lookup PC 0x100: resp_hit=0, resp_taken=0, resp_target=0, resp_idx=0.
- Update branch 0x100, taken, target 0x2000; next cycle lookup 0x100: hit=1, taken=1 (counter 10), target=0x2000. Then two not-taken updates: the counter reads 00, taken=0. A third not-taken update keeps 00.
- Fill 8 entries with taken jumps to distinct PCs, then allocate a 9th: entry 0 is evicted. Allocate a 10th: entry 1 is evicted. Re-updating an existing PC causes no new allocation (no duplicate).
- Update call at 0x40 (push 0x44) and ret at 0x80 with stale target 0x0; lookup 0x80: target=0x44. Pop on the ret update; lookup 0x80 again: RAS is empty, target=0x0.
- Push 5 values into the 4-deep RAS (0x10..0x50): top=0x50. After four pops the RAS is empty. A fifth pop changes nothing.
- inv_valid asserted with a same-cycle taken update to a new PC: the next lookup of every PC misses and rr=0.

Source files
------------

// File: rtl/bpu_btb.sv
// Fetch-stage branch predictor: fully associative BTB with saturating counters
// and a circular return address stack, updated from resolved EXU outcomes.
module bpu_btb #(
  parameter int ADDR_BITS = 30,
  parameter int DATA_BITS = 32,
  parameter int ENTRIES   = 8,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4,
  parameter int IDX_W     = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  input  logic [ADDR_BITS-1:0] req_pc,
  output logic                 resp_hit,
  output logic                 resp_taken,
  output logic [IDX_W-1:0]     resp_idx,
  output logic [DATA_BITS-1:0] resp_target,
  input  logic                 upd_valid,
  input  logic [ADDR_BITS-1:0] upd_pc,
  input  logic [1:0]           upd_kind,
  input  logic                 upd_taken,
  input  logic [DATA_BITS-1:0] upd_target,
  input  logic                 upd_ras_push,
  input  logic                 upd_ras_pop,
  input  logic [DATA_BITS-1:0] upd_ras_pc,
  input  logic                 inv_valid
);

  localparam int SP_W = $clog2(RAS_DEPTH);
  localparam int RC_W = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] KIND_BR  = 2'b00;
  localparam logic [1:0] KIND_RET = 2'b11;

  localparam logic [CNT_BITS-1:0] CTR_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CTR_MAX  = '1;
  localparam logic [RC_W-1:0]     RAS_FULL = RC_W'(RAS_DEPTH);

  logic [ENTRIES-1:0]   btb_valid;
  logic [ADDR_BITS-1:0] btb_tag    [ENTRIES];
  logic [DATA_BITS-1:0] btb_target [ENTRIES];
  logic [CNT_BITS-1:0]  btb_ctr    [ENTRIES];
  logic [1:0]           btb_kind   [ENTRIES];
  logic [IDX_W-1:0]     rr;

  logic [DATA_BITS-1:0] ras_mem [RAS_DEPTH];
  logic [SP_W-1:0]      ras_sp;
  logic [RC_W-1:0]      ras_cnt;

  // Saturating up/down counter step.
  function automatic logic [CNT_BITS-1:0] ctr_step(input logic [CNT_BITS-1:0] c,
                                                   input logic up);
    if (up)
      return (c == CTR_MAX) ? c : c + CNT_BITS'(1);
    else
      return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  // Lookup match: descending scan so the lowest matching index wins.
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (req_valid && btb_valid[i] && (btb_tag[i] == req_pc)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  logic ras_empty;
  assign ras_empty = (ras_cnt == '0);

  assign resp_hit    = lk_hit;
  assign resp_idx    = lk_idx;
  assign resp_taken  = lk_hit & btb_ctr[lk_idx][CNT_BITS-1];
  assign resp_target = !lk_hit ? '0 :
                       ((btb_kind[lk_idx] == KIND_RET) && !ras_empty) ? ras_mem[ras_sp] :
                       btb_target[lk_idx];

  // Update-port match and allocation slot, independent of the lookup port.
  logic             um_hit;
  logic [IDX_W-1:0] um_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             upd_is_taken;

  always_comb begin
    um_hit     = 1'b0;
    um_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (btb_valid[i] && (btb_tag[i] == upd_pc)) begin
        um_hit = 1'b1;
        um_idx = IDX_W'(i);
      end
      if (!btb_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign alloc_idx    = free_found ? free_idx : rr;
  assign upd_is_taken = upd_taken | (upd_kind != KIND_BR);

  // BTB state; invalidate drops any same-cycle update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btb_valid <= '0;
      rr        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= '0;
        btb_kind[i]   <= '0;
      end
    end else if (inv_valid) begin
      btb_valid <= '0;
      rr        <= '0;
    end else if (upd_valid) begin
      if (um_hit) begin
        btb_ctr[um_idx] <= (upd_kind != KIND_BR) ? CTR_MAX : ctr_step(btb_ctr[um_idx], upd_taken);
        if (upd_is_taken) begin
          btb_target[um_idx] <= upd_target;
          btb_kind[um_idx]   <= upd_kind;
        end
      end else if (upd_is_taken) begin
        btb_valid[alloc_idx]  <= 1'b1;
        btb_tag[alloc_idx]    <= upd_pc;
        btb_target[alloc_idx] <= upd_target;
        btb_kind[alloc_idx]   <= upd_kind;
        btb_ctr[alloc_idx]    <= (upd_kind == KIND_BR) ? CTR_WEAK : CTR_MAX;
        if (!free_found)
          rr <= rr + IDX_W'(1);
      end
    end
  end

  logic [SP_W-1:0] sp_inc;
  logic [SP_W-1:0] sp_dec;
  assign sp_inc = ras_sp + SP_W'(1);
  assign sp_dec = ras_sp - SP_W'(1);

  // RAS: push+pop on a non-empty stack replaces the top in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_mem[i] <= '0;
    end else if (upd_ras_push && (!upd_ras_pop || ras_empty)) begin
      ras_sp          <= sp_inc;
      ras_mem[sp_inc] <= upd_ras_pc;
      if (ras_cnt != RAS_FULL)
        ras_cnt <= ras_cnt + RC_W'(1);
    end else if (upd_ras_push && upd_ras_pop) begin
      ras_mem[ras_sp] <= upd_ras_pc;
    end else if (upd_ras_pop && !ras_empty) begin
      ras_sp  <= sp_dec;
      ras_cnt <= ras_cnt - RC_W'(1);
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb: counters, allocation/eviction, RAS and invalidate.
module tb_bpu_btb;

  localparam logic [1:0] BR   = 2'b00;
  localparam logic [1:0] JMP  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic [29:0] req_pc;
  logic        resp_hit;
  logic        resp_taken;
  logic [2:0]  resp_idx;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_ras_push;
  logic        upd_ras_pop;
  logic [31:0] upd_ras_pc;
  logic        inv_valid;

  int nvec;
  int nerr;

  bpu_btb #(
    .ADDR_BITS(30), .DATA_BITS(32), .ENTRIES(8), .CNT_BITS(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_pc(req_pc),
    .resp_hit(resp_hit), .resp_taken(resp_taken), .resp_idx(resp_idx), .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ras_push(upd_ras_push), .upd_ras_pop(upd_ras_pop),
    .upd_ras_pc(upd_ras_pc), .inv_valid(inv_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of update/RAS/invalidate stimulus, driven at negedge.
  task automatic cycle(input logic v, input logic [29:0] pc, input logic [1:0] kind,
                       input logic tk, input logic [31:0] tgt, input logic push,
                       input logic pop, input logic [31:0] rpc, input logic inv);
    @(negedge clk);
    upd_valid = v; upd_pc = pc; upd_kind = kind; upd_taken = tk; upd_target = tgt;
    upd_ras_push = push; upd_ras_pop = pop; upd_ras_pc = rpc; inv_valid = inv;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_ras_push = 1'b0; upd_ras_pop = 1'b0; inv_valid = 1'b0;
  endtask

  task automatic look(input logic [29:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req_valid = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_kind = '0; upd_taken = 1'b0; upd_target = '0;
    upd_ras_push = 1'b0; upd_ras_pop = 1'b0; upd_ras_pc = '0; inv_valid = 1'b0;
    #13;
    look(30'h100);
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== 37'h0) begin
      nerr++;
      $display("FAIL reset_during: got %h want 0", {resp_hit, resp_taken, resp_idx, resp_target});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    look(30'h100);
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== 37'h0) begin
      nerr++;
      $display("FAIL reset_after: got %h want 0", {resp_hit, resp_taken, resp_idx, resp_target});
    end
  endtask

  task automatic test_counter;
    logic tk_seq   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic want_seq [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cycle(1'b1, 30'h100, BR, 1'b1, 32'h2000, 1'b0, 1'b0, '0, 1'b0);
    look(30'h100);
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== {1'b1, 1'b1, 3'd0, 32'h2000}) begin
      nerr++;
      $display("FAIL ctr_alloc: got %h want %h", {resp_hit, resp_taken, resp_idx, resp_target},
               {1'b1, 1'b1, 3'd0, 32'h2000});
    end
    for (int s = 0; s < 9; s++) begin
      cycle(1'b1, 30'h100, BR, tk_seq[s], 32'h2000, 1'b0, 1'b0, '0, 1'b0);
      look(30'h100);
      nvec++;
      if ({resp_hit, resp_taken, resp_target} !== {1'b1, want_seq[s], 32'h2000}) begin
        nerr++;
        $display("FAIL ctr_step%0d: got %h want %h", s, {resp_hit, resp_taken, resp_target},
                 {1'b1, want_seq[s], 32'h2000});
      end
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 30'h300; upd_kind = JMP; upd_taken = 1'b1; upd_target = 32'h3300;
    look(30'h300);
    nvec++;
    if ({resp_hit, resp_target} !== {1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL same_cycle_pre: got %h want 0", {resp_hit, resp_target});
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    look(30'h300);
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== {1'b1, 1'b1, 3'd1, 32'h3300}) begin
      nerr++;
      $display("FAIL same_cycle_post: got %h want %h", {resp_hit, resp_taken, resp_idx, resp_target},
               {1'b1, 1'b1, 3'd1, 32'h3300});
    end
    req_valid = 1'b0;
    #1;
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== 37'h0) begin
      nerr++;
      $display("FAIL req_idle: got %h want 0", {resp_hit, resp_taken, resp_idx, resp_target});
    end
    cycle(1'b1, 30'h310, BR, 1'b0, 32'h3310, 1'b0, 1'b0, '0, 1'b0);
    look(30'h310);
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== 37'h0) begin
      nerr++;
      $display("FAIL miss_not_taken: got %h want 0", {resp_hit, resp_taken, resp_idx, resp_target});
    end
  endtask

  task automatic test_fill_evict;
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    look(30'h100);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL inv_clear: hit=%b want 0", resp_hit);
    end
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 30'h1000 + 30'(i), JMP, 1'b1, 32'h8000 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      look(30'h1000 + 30'(i));
      nvec++;
      if ({resp_hit, resp_taken, resp_idx, resp_target} !== {1'b1, 1'b1, 3'(i), 32'h8000 + 32'(4 * i)}) begin
        nerr++;
        $display("FAIL fill%0d: got %h want %h", i, {resp_hit, resp_taken, resp_idx, resp_target},
                 {1'b1, 1'b1, 3'(i), 32'h8000 + 32'(4 * i)});
      end
    end
    cycle(1'b1, 30'h2000, JMP, 1'b1, 32'h9000, 1'b0, 1'b0, '0, 1'b0);
    look(30'h2000);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd0, 32'h9000}) begin
      nerr++;
      $display("FAIL evict9: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd0, 32'h9000});
    end
    look(30'h1000);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL evict9_old: hit=%b want 0", resp_hit);
    end
    cycle(1'b1, 30'h2001, JMP, 1'b1, 32'h9004, 1'b0, 1'b0, '0, 1'b0);
    look(30'h2001);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd1, 32'h9004}) begin
      nerr++;
      $display("FAIL evict10: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd1, 32'h9004});
    end
    look(30'h1001);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL evict10_old: hit=%b want 0", resp_hit);
    end
    cycle(1'b1, 30'h1005, JMP, 1'b1, 32'hAAAA, 1'b0, 1'b0, '0, 1'b0);
    look(30'h1005);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd5, 32'hAAAA}) begin
      nerr++;
      $display("FAIL rehit: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd5, 32'hAAAA});
    end
    cycle(1'b1, 30'h2002, JMP, 1'b1, 32'h9008, 1'b0, 1'b0, '0, 1'b0);
    look(30'h2002);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd2, 32'h9008}) begin
      nerr++;
      $display("FAIL evict11: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd2, 32'h9008});
    end
    look(30'h1003);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd3, 32'h800C}) begin
      nerr++;
      $display("FAIL survivor: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd3, 32'h800C});
    end
  endtask

  task automatic test_call_ret;
    cycle(1'b1, 30'h40, CALL, 1'b1, 32'h500, 1'b1, 1'b0, 32'h44, 1'b0);
    cycle(1'b1, 30'h80, RET, 1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    look(30'h80);
    nvec++;
    if ({resp_hit, resp_taken, resp_target} !== {1'b1, 1'b1, 32'h44}) begin
      nerr++;
      $display("FAIL ret_ras: got %h want %h", {resp_hit, resp_taken, resp_target}, {1'b1, 1'b1, 32'h44});
    end
    look(30'h40);
    nvec++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h500}) begin
      nerr++;
      $display("FAIL call_target: got %h want %h", {resp_hit, resp_target}, {1'b1, 32'h500});
    end
    cycle(1'b1, 30'h80, RET, 1'b1, 32'h0, 1'b0, 1'b1, '0, 1'b0);
    look(30'h80);
    nvec++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL ret_empty: got %h want %h", {resp_hit, resp_target}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_ras_wrap;
    logic [31:0] pop_want [5] = '{32'h40, 32'h30, 32'h20, 32'h0, 32'h0};
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, '0, BR, 1'b0, '0, 1'b1, 1'b0, 32'(16 * i), 1'b0);
    look(30'h80);
    nvec++;
    if (resp_target !== 32'h50) begin
      nerr++;
      $display("FAIL ras_top: got %h want 50", resp_target);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, BR, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
      look(30'h80);
      nvec++;
      if (resp_target !== pop_want[i]) begin
        nerr++;
        $display("FAIL ras_pop%0d: got %h want %h", i, resp_target, pop_want[i]);
      end
    end
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b1, 1'b0, 32'h60, 1'b0);
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b1, 1'b1, 32'h70, 1'b0);
    look(30'h80);
    nvec++;
    if (resp_target !== 32'h70) begin
      nerr++;
      $display("FAIL ras_pushpop: got %h want 70", resp_target);
    end
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    look(30'h80);
    nvec++;
    if (resp_target !== 32'h0) begin
      nerr++;
      $display("FAIL ras_pushpop_cnt: got %h want 0", resp_target);
    end
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b1, 1'b1, 32'h90, 1'b0);
    look(30'h80);
    nvec++;
    if (resp_target !== 32'h90) begin
      nerr++;
      $display("FAIL ras_pushpop_empty: got %h want 90", resp_target);
    end
  endtask

  task automatic test_invalidate;
    cycle(1'b0, '0, BR, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 30'h4000 + 30'(i), JMP, 1'b1, 32'hC000, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 30'h4100, JMP, 1'b1, 32'hC100, 1'b0, 1'b0, '0, 1'b0);
    look(30'h4100);
    nvec++;
    if ({resp_hit, resp_idx} !== {1'b1, 3'd0}) begin
      nerr++;
      $display("FAIL inv_pre: got %h want %h", {resp_hit, resp_idx}, {1'b1, 3'd0});
    end
    cycle(1'b1, 30'h4200, JMP, 1'b1, 32'hC200, 1'b0, 1'b0, '0, 1'b1);
    look(30'h4200);
    nvec++;
    if ({resp_hit, resp_target} !== 33'h0) begin
      nerr++;
      $display("FAIL inv_drop_upd: got %h want 0", {resp_hit, resp_target});
    end
    look(30'h4100);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL inv_miss_a: hit=%b want 0", resp_hit);
    end
    look(30'h4003);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL inv_miss_b: hit=%b want 0", resp_hit);
    end
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 30'h5000 + 30'(i), JMP, 1'b1, 32'hD000, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 30'h5100, JMP, 1'b1, 32'hD100, 1'b0, 1'b0, '0, 1'b0);
    look(30'h5100);
    nvec++;
    if ({resp_hit, resp_idx, resp_target} !== {1'b1, 3'd0, 32'hD100}) begin
      nerr++;
      $display("FAIL inv_rr: got %h want %h", {resp_hit, resp_idx, resp_target}, {1'b1, 3'd0, 32'hD100});
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2;
    look(30'h5100);
    rstn = 1'b0;
    #1;
    nvec++;
    if ({resp_hit, resp_taken, resp_idx, resp_target} !== 37'h0) begin
      nerr++;
      $display("FAIL async_reset: got %h want 0", {resp_hit, resp_taken, resp_idx, resp_target});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    look(30'h5003);
    nvec++;
    if (resp_hit !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset_after: hit=%b want 0", resp_hit);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_counter();
    test_same_cycle();
    test_fill_evict();
    test_call_ret();
    test_ras_wrap();
    test_invalidate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
